// File: rtl/vx_l1_mem_arbiter_pkg.sv
// Shared sizing for the L1-to-L2 memory arbiter.
// The source index is appended below the L1 tag to form the L2 tag.
package vx_l1_mem_arbiter_pkg;

  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_L1_OUTPUTS       = 5;
  localparam int L1_MEM_TAG_WIDTH     = 12;
  localparam int L1_MEM_ARB_SEL_BITS  = up_clog2(NUM_L1_OUTPUTS);
  localparam int L1_MEM_ARB_TAG_WIDTH = L1_MEM_TAG_WIDTH
                                      + L1_MEM_ARB_SEL_BITS;
  localparam int L2_TAG_WIDTH         = L1_MEM_ARB_TAG_WIDTH;

endpackage

// File: rtl/vx_mem_elastic_buf2.sv
// Two-entry valid/ready buffer; registered outputs, full rate.
// Readiness depends only on occupancy, never on out_ready.
module vx_mem_elastic_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = slot[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= in_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/vx_l1_mem_arbiter.sv
// Round-robin L1-to-L2 request arbiter with per-source read credit
// limits and index-routed responses.
module vx_l1_mem_arbiter
  import vx_l1_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQS     = NUM_L1_OUTPUTS,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_IN_WIDTH = L1_MEM_TAG_WIDTH,
  parameter int MAX_PENDING  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        req_valid,
  input  logic [NUM_REQS-1:0]        req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0] req_byteen,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]        req_ready,
  output logic [NUM_REQS-1:0]        rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [TAG_IN_WIDTH-1:0]    rsp_tag,
  input  logic [NUM_REQS-1:0]        rsp_ready,
  output logic                       mem_req_valid,
  output logic                       mem_req_rw,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr,
  output logic [DATA_WIDTH-1:0]      mem_req_data,
  output logic [DATA_WIDTH/8-1:0]    mem_req_byteen,
  output logic [TAG_IN_WIDTH+up_clog2(NUM_REQS)-1:0] mem_req_tag,
  input  logic                       mem_req_ready,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rsp_data,
  input  logic [TAG_IN_WIDTH+up_clog2(NUM_REQS)-1:0] mem_rsp_tag,
  output logic                       mem_rsp_ready,
  output logic                       rsp_orphan
);

  localparam int SEL_BITS  = up_clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS;
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_PENDING + 1);
  localparam int PAY_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH
                           + BE_WIDTH + TAG_OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = CNT_WIDTH'(MAX_PENDING);
  localparam logic [SEL_BITS-1:0]  LAST     = SEL_BITS'(NUM_REQS - 1);

  logic [SEL_BITS-1:0]     rr_ptr;
  logic [SEL_BITS-1:0]     gnt_idx;
  logic [SEL_BITS-1:0]     scan;
  logic [SEL_BITS-1:0]     rsp_idx;
  logic [CNT_WIDTH-1:0]    pend [NUM_REQS];
  logic [NUM_REQS-1:0]     elig;
  logic [NUM_REQS-1:0]     inc;
  logic [NUM_REQS-1:0]     dec;
  logic                    gnt_found;
  logic                    buf_ready;
  logic                    push;
  logic                    sel_rw;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [BE_WIDTH-1:0]     sel_be;
  logic [TAG_IN_WIDTH-1:0] sel_tag;
  logic [PAY_WIDTH-1:0]    in_pay;
  logic [PAY_WIDTH-1:0]    out_pay;
  logic                    rsp_hit;
  logic                    rsp_zero;
  logic                    rsp_rdy;
  logic                    rsp_hs;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = req_valid[i] && (req_rw[i] || pend[i] < PEND_MAX);
    end
  end

  // Scan starts one past the last winner and wraps at NUM_REQS.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = rr_ptr;
    for (int k = 0; k < NUM_REQS; k++) begin
      scan = (scan == LAST) ? '0 : scan + 1'b1;
      if (!gnt_found && elig[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan;
      end
    end
  end

  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_be   = '0;
    sel_tag  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (gnt_idx == SEL_BITS'(i)) begin
        sel_rw   = req_rw[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be   = req_byteen[i*BE_WIDTH +: BE_WIDTH];
        sel_tag  = req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
        req_ready[i] = gnt_found && buf_ready;
      end
    end
  end

  assign push   = gnt_found && buf_ready;
  assign in_pay = {sel_rw, sel_addr, sel_data, sel_be,
                   sel_tag, gnt_idx};

  vx_mem_elastic_buf2 #(
    .WIDTH (PAY_WIDTH)
  ) req_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (gnt_found),
    .in_data   (in_pay),
    .in_ready  (buf_ready),
    .out_valid (mem_req_valid),
    .out_data  (out_pay),
    .out_ready (mem_req_ready)
  );

  assign {mem_req_rw, mem_req_addr, mem_req_data,
          mem_req_byteen, mem_req_tag} = out_pay;

  assign rsp_idx = mem_rsp_tag[SEL_BITS-1:0];

  // Unknown indices are swallowed so a bad tag cannot wedge L2.
  always_comb begin
    rsp_valid = '0;
    rsp_hit   = 1'b0;
    rsp_zero  = 1'b0;
    rsp_rdy   = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx == SEL_BITS'(i)) begin
        rsp_hit      = 1'b1;
        rsp_zero     = (pend[i] == '0);
        rsp_rdy      = rsp_ready[i];
        rsp_valid[i] = mem_rsp_valid;
      end
    end
  end

  assign mem_rsp_ready = rsp_rdy;
  assign rsp_data      = mem_rsp_data;
  assign rsp_tag       = mem_rsp_tag[TAG_OUT_WIDTH-1:SEL_BITS];
  assign rsp_hs        = mem_rsp_valid && rsp_rdy;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      inc[i] = push && !sel_rw && (gnt_idx == SEL_BITS'(i));
      dec[i] = rsp_hs && (rsp_idx == SEL_BITS'(i))
             && (pend[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= LAST;
      rsp_orphan <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
        pend[i] <= '0;
      end
    end else begin
      if (push) begin
        rr_ptr <= gnt_idx;
      end
      if (rsp_hs && (!rsp_hit || rsp_zero)) begin
        rsp_orphan <= 1'b1;
      end
      for (int i = 0; i < NUM_REQS; i++) begin
        if (inc[i] && !dec[i]) begin
          pend[i] <= pend[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_l1_mem_arbiter.sv
// Bench for vx_l1_mem_arbiter: directed scenarios plus random
// traffic against a queue-level reference model.
module tb_vx_l1_mem_arbiter;

  localparam int N  = 5;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int BW = 64;
  localparam int TW = 12;
  localparam int OW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_rw, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*BW-1:0] req_byteen;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]  rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [BW-1:0] mem_req_byteen;
  logic [OW-1:0] mem_req_tag;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic [OW-1:0] mem_rsp_tag;
  logic          rsp_orphan;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [OW-1:0] tag;
  } mreq_t;

  mreq_t mq[$];
  int    m_pend[N];
  int    m_last;
  bit    m_orphan;

  vx_l1_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data),
    .req_byteen(req_byteen), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .rsp_orphan(rsp_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model: a 2-deep request queue, pending counts per
  // source, last-winner pointer and a sticky orphan flag.
  task automatic m_reset();
    mq.delete();
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_last   = N - 1;
    m_orphan = 1'b0;
  endtask

  function automatic int m_grant();
    if (mq.size() >= 2) return -1;
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (req_valid[j] && (req_rw[j] || m_pend[j] < 8)) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g = m_grant();
    return (g >= 0) ? N'(1 << g) : '0;
  endfunction

  function automatic bit m_mrr();
    int idx = int'(mem_rsp_tag[2:0]);
    if (idx >= N) return 1'b1;
    return rsp_ready[idx];
  endfunction

  task automatic m_clock();
    int    g;
    int    idx;
    mreq_t e;
    g   = m_grant();
    idx = int'(mem_rsp_tag[2:0]);
    if (mem_rsp_valid && m_mrr()) begin
      if (idx >= N || m_pend[idx] == 0) m_orphan = 1'b1;
      else m_pend[idx]--;
    end
    if (mq.size() > 0 && mem_req_ready) void'(mq.pop_front());
    if (g >= 0) begin
      e.rw   = req_rw[g];
      e.addr = req_addr[g*AW +: AW];
      e.data = req_data[g*DW +: DW];
      e.be   = req_byteen[g*BW +: BW];
      e.tag  = {req_tag[g*TW +: TW], 3'(g)};
      mq.push_back(e);
      m_last = g;
      if (!e.rw) m_pend[g]++;
    end
  endtask

  task automatic adv();
    m_clock();
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]   = AW'($urandom);
      req_data[i*DW +: DW]   = {16{$urandom}};
      req_byteen[i*BW +: BW] = {$urandom, $urandom};
      req_tag[i*TW +: TW]    = TW'($urandom);
    end
  endtask

  task automatic clear_inputs();
    req_valid     = '0;
    req_rw        = '0;
    rand_payload();
    rsp_ready     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (mem_req_valid !== 1'b0 || rsp_orphan !== 1'b0) begin
      fails++;
      $display("FAIL rst_outputs got valid=%b orphan=%b exp 0 0",
               mem_req_valid, rsp_orphan);
    end
    tests++;
    if (mem_req_tag !== '0 || mem_req_addr !== '0) begin
      fails++;
      $display("FAIL rst_payload got tag=%h addr=%h exp 0",
               mem_req_tag, mem_req_addr);
    end
    tests++;
    if (rsp_valid !== '0 || req_ready !== '0) begin
      fails++;
      $display("FAIL rst_idle got rsp_valid=%b req_ready=%b exp 0",
               rsp_valid, req_ready);
    end
    req_valid = 5'h1f;
    #1;
    tests++;
    if (req_ready !== 5'b00001) begin
      fails++;
      $display("FAIL rst_priority got %b exp 00001", req_ready);
    end
    mem_rsp_tag = {12'h000, 3'd2};
    rsp_ready   = 5'b00100;
    #1;
    tests++;
    if (mem_rsp_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_rsp_ready got %b exp 1", mem_rsp_ready);
    end
    clear_inputs();
    m_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    req_valid     = 5'h1f;
    req_rw        = '0;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (c < 6) begin
        tests++;
        if (req_ready !== N'(1 << order[c])) begin
          fails++;
          $display("FAIL rr_grant c=%0d got %b exp %b",
                   c, req_ready, N'(1 << order[c]));
        end
      end
      tests++;
      if (mem_req_valid !== (c > 0)) begin
        fails++;
        $display("FAIL rr_latency c=%0d got %b exp %b",
                 c, mem_req_valid, (c > 0));
      end
      if (c > 0) begin
        tests++;
        if (mem_req_tag !== {req_tag[order[c-1]*TW +: TW],
                             3'(order[c-1])} ||
            mem_req_addr !== req_addr[order[c-1]*AW +: AW]) begin
          fails++;
          $display("FAIL rr_tag c=%0d got %h exp idx %0d",
                   c, mem_req_tag, order[c-1]);
        end
      end
      adv();
    end
  endtask

  task automatic test_pending_limit();
    do_reset();
    req_valid     = 5'b00010;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      tests++;
      if (req_ready !== 5'b00010) begin
        fails++;
        $display("FAIL pend_accept c=%0d got %b exp 00010",
                 c, req_ready);
      end
      adv();
    end
    #1;
    tests++;
    if (req_ready !== 5'b00000) begin
      fails++;
      $display("FAIL pend_block got %b exp 00000", req_ready);
    end
    req_rw = 5'b00010;
    #1;
    tests++;
    if (req_ready !== 5'b00010) begin
      fails++;
      $display("FAIL pend_write got %b exp 00010", req_ready);
    end
    adv();
    req_rw        = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {12'h123, 3'd1};
    rsp_ready     = 5'b00010;
    #1;
    tests++;
    if (req_ready !== '0 || rsp_valid !== 5'b00010 ||
        mem_rsp_ready !== 1'b1) begin
      fails++;
      $display("FAIL pend_rsp got rdy=%b rv=%b mrr=%b exp 0 00010 1",
               req_ready, rsp_valid, mem_rsp_ready);
    end
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    tests++;
    if (req_ready !== 5'b00010) begin
      fails++;
      $display("FAIL pend_credit got %b exp 00010", req_ready);
    end
    adv();
    #1;
    tests++;
    if (req_ready !== 5'b00000) begin
      fails++;
      $display("FAIL pend_reblock got %b exp 00000", req_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] snap_tag;
    logic [AW-1:0] snap_addr;
    int            hs = 0;
    do_reset();
    req_valid = 5'h1f;
    req_rw    = N'($urandom);
    snap_tag  = '0;
    snap_addr = '0;
    for (int c = 0; c < 10; c++) begin
      mem_req_ready = (c >= 4);
      #1;
      tests++;
      if (req_ready !== m_ready()) begin
        fails++;
        $display("FAIL bp_grant c=%0d got %b exp %b",
                 c, req_ready, m_ready());
      end
      if (c == 2 || c == 3) begin
        tests++;
        if (req_ready !== '0 || mem_req_valid !== 1'b1) begin
          fails++;
          $display("FAIL bp_full c=%0d got rdy=%b v=%b exp 0 1",
                   c, req_ready, mem_req_valid);
        end
      end
      if (c == 1) begin
        snap_tag  = mem_req_tag;
        snap_addr = mem_req_addr;
      end
      if (c >= 2 && c <= 4) begin
        tests++;
        if (mem_req_tag !== snap_tag || mem_req_addr !== snap_addr) begin
          fails++;
          $display("FAIL bp_stable c=%0d got %h exp %h",
                   c, mem_req_tag, snap_tag);
        end
      end
      if (c >= 5 && req_ready !== '0 && mem_req_valid) hs++;
      adv();
    end
    tests++;
    if (hs != 5) begin
      fails++;
      $display("FAIL bp_throughput got %0d exp 5", hs);
    end
  endtask

  task automatic test_response_route();
    logic [DW-1:0] d;
    do_reset();
    req_valid     = 5'b00100;
    mem_req_ready = 1'b1;
    adv();
    req_valid = '0;
    adv();
    d             = {16{$urandom}};
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    mem_rsp_tag   = {12'hABC, 3'd2};
    rsp_ready     = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (rsp_valid !== 5'b00100 || rsp_tag !== 12'hABC ||
          rsp_data !== d || mem_rsp_ready !== 1'b0) begin
        fails++;
        $display("FAIL route_stall c=%0d got rv=%b tag=%h mrr=%b",
                 c, rsp_valid, rsp_tag, mem_rsp_ready);
      end
      adv();
    end
    rsp_ready = 5'b00100;
    #1;
    tests++;
    if (mem_rsp_ready !== 1'b1) begin
      fails++;
      $display("FAIL route_ready got %b exp 1", mem_rsp_ready);
    end
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    tests++;
    if (rsp_orphan !== 1'b0) begin
      fails++;
      $display("FAIL route_no_orphan got %b exp 0", rsp_orphan);
    end
    mem_rsp_valid = 1'b1;
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    tests++;
    if (rsp_orphan !== 1'b1) begin
      fails++;
      $display("FAIL route_dec_once got orphan=%b exp 1", rsp_orphan);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {12'h5A5, 3'd6};
    rsp_ready     = '0;
    #1;
    tests++;
    if (mem_rsp_ready !== 1'b1 || rsp_valid !== '0 ||
        rsp_orphan !== 1'b0) begin
      fails++;
      $display("FAIL orph_badidx got mrr=%b rv=%b o=%b exp 1 0 0",
               mem_rsp_ready, rsp_valid, rsp_orphan);
    end
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    tests++;
    if (rsp_orphan !== m_orphan || rsp_orphan !== 1'b1) begin
      fails++;
      $display("FAIL orph_set got %b exp 1", rsp_orphan);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {12'h3C3, 3'd0};
    rsp_ready     = 5'h1f;
    #1;
    tests++;
    if (rsp_valid !== 5'b00001 || rsp_tag !== 12'h3C3) begin
      fails++;
      $display("FAIL orph_zero_fwd got rv=%b tag=%h exp 00001 3c3",
               rsp_valid, rsp_tag);
    end
    adv();
    mem_rsp_valid = 1'b0;
    adv();
    adv();
    #1;
    tests++;
    if (rsp_orphan !== 1'b1) begin
      fails++;
      $display("FAIL orph_sticky got %b exp 1", rsp_orphan);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_valid     = 5'b00001;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      tests++;
      if (req_ready !== 5'b00001) begin
        fails++;
        $display("FAIL same_fill c=%0d got %b exp 00001", c, req_ready);
      end
      adv();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {12'h0F0, 3'd0};
    rsp_ready     = 5'b00001;
    #1;
    tests++;
    if (req_ready !== 5'b00001 || mem_rsp_ready !== 1'b1) begin
      fails++;
      $display("FAIL same_both got rdy=%b mrr=%b exp 00001 1",
               req_ready, mem_rsp_ready);
    end
    adv();
    mem_rsp_valid = 1'b0;
    #1;
    tests++;
    if (req_ready !== 5'b00001) begin
      fails++;
      $display("FAIL same_hold got %b exp 00001", req_ready);
    end
    adv();
    #1;
    tests++;
    if (req_ready !== 5'b00000 || rsp_orphan !== 1'b0) begin
      fails++;
      $display("FAIL same_limit got rdy=%b o=%b exp 0 0",
               req_ready, rsp_orphan);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid     = 5'b01000;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) adv();
    req_rw        = 5'b01000;
    mem_req_ready = 1'b0;
    adv();
    adv();
    #1;
    tests++;
    if (mem_req_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy got %b exp 1", mem_req_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_async got %b exp 0", mem_req_valid);
    end
    m_reset();
    @(negedge clk);
    reset         = 1'b1;
    req_rw        = '0;
    mem_req_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 5'b01000 || mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_clear got rdy=%b v=%b exp 01000 0",
               req_ready, mem_req_valid);
    end
    adv();
  endtask

  task automatic test_random();
    logic [OW-1:0] out_tags[$];
    logic [N-1:0]  exp_rv;
    int            pk;
    int            idx;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_payload();
      req_valid     = N'($urandom);
      req_rw        = N'($urandom) & N'($urandom);
      mem_req_ready = ($urandom_range(3, 0) != 0);
      rsp_ready     = N'($urandom) | N'($urandom);
      pk            = -1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {16{$urandom}};
      if (out_tags.size() > 0 && $urandom_range(1, 0) == 1) begin
        pk            = $urandom_range(out_tags.size() - 1, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = out_tags[pk];
      end
      #1;
      tests++;
      if (req_ready !== m_ready()) begin
        fails++;
        $display("FAIL rnd_grant c=%0d got %b exp %b",
                 c, req_ready, m_ready());
      end
      tests++;
      if (mem_req_valid !== (mq.size() > 0)) begin
        fails++;
        $display("FAIL rnd_mvalid c=%0d got %b exp %0d",
                 c, mem_req_valid, mq.size());
      end
      if (mq.size() > 0) begin
        tests++;
        if ({mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen,
             mem_req_tag} !== {mq[0].rw, mq[0].addr, mq[0].data,
                               mq[0].be, mq[0].tag}) begin
          fails++;
          $display("FAIL rnd_mreq c=%0d got tag=%h addr=%h exp %h %h",
                   c, mem_req_tag, mem_req_addr, mq[0].tag, mq[0].addr);
        end
      end
      idx    = int'(mem_rsp_tag[2:0]);
      exp_rv = (mem_rsp_valid && idx < N) ? N'(1 << idx) : '0;
      tests++;
      if (rsp_valid !== exp_rv || mem_rsp_ready !== m_mrr()) begin
        fails++;
        $display("FAIL rnd_rsp c=%0d got rv=%b mrr=%b exp %b %b",
                 c, rsp_valid, mem_rsp_ready, exp_rv, m_mrr());
      end
      if (mem_rsp_valid) begin
        tests++;
        if (rsp_tag !== mem_rsp_tag[OW-1:3] ||
            rsp_data !== mem_rsp_data) begin
          fails++;
          $display("FAIL rnd_rsp_tag c=%0d got %h exp %h",
                   c, rsp_tag, mem_rsp_tag[OW-1:3]);
        end
      end
      tests++;
      if (rsp_orphan !== m_orphan) begin
        fails++;
        $display("FAIL rnd_orphan c=%0d got %b exp %b",
                 c, rsp_orphan, m_orphan);
      end
      if (mq.size() > 0 && mem_req_ready && !mq[0].rw)
        out_tags.push_back(mq[0].tag);
      if (pk >= 0 && m_mrr()) out_tags.delete(pk);
      adv();
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_round_robin();
    test_pending_limit();
    test_backpressure();
    test_response_route();
    test_orphan();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
